sim_ctrl: RTL

SIM_CTRL -- requirements
Module: sim_ctrl

---
 rtl/sim_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sim_ctrl.sv
// Simulation controller: holds the DUT in reset, snoops AXI writes to the tohost mailbox and reports pass/fail/timeout.
// Optional bus-stall watchdog is enabled by defining SIM_CTRL_STALL_WDG_EN.
module sim_ctrl #(
   parameter int unsigned         RST_CYCLES     = 20,
   parameter int unsigned         TIMEOUT_CYCLES = 200000,
   parameter int unsigned         CNT_W          = 32,
   parameter int unsigned         ADDR_W         = 32,
   parameter int unsigned         DATA_W         = 32,
   parameter logic [ADDR_W-1:0]   TOHOST_ADDR    = ADDR_W'(32'h8000_1000),
   parameter int unsigned         STALL_CYCLES   = 10000
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              AWVALID,
   input  logic              AWREADY,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              WVALID,
   input  logic              WREADY,
   input  logic [DATA_W-1:0] WDATA,
   output logic              dut_rst,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [DATA_W-1:0] exit_code,
   output logic [CNT_W-1:0]  cycle_count
);

   typedef enum logic [2:0] {RST_HOLD, RUN, PASS, FAIL, TMO} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    hold_q, hold_d;
   logic [CNT_W-1:0]    cycle_q, cycle_d;
   logic                aw_pend_q, aw_pend_d;
   logic                w_pend_q, w_pend_d;
   logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0]   w_data_q, w_data_d;
   logic                dut_rst_q, dut_rst_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic                fail_q, fail_d;
   logic                tmo_q, tmo_d;
   logic [DATA_W-1:0]   exit_q, exit_d;

   logic                run, aw_hs, w_hs, aw_take, w_take, eval;
   logic [ADDR_W-1:0]   ev_addr;
   logic [DATA_W-1:0]   ev_data;
   logic                is_pass, is_fail, budget_exp, stall_exp;

   assign run     = (state_q == RUN);
   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;
   assign aw_take = run & aw_hs & ~aw_pend_q;
   assign w_take  = run & w_hs & ~w_pend_q;
   // A pair is evaluated as soon as both halves exist, whether latched earlier or arriving now.
   assign eval    = (aw_pend_q | aw_take) & (w_pend_q | w_take);
   assign ev_addr = aw_pend_q ? aw_addr_q : AWADDR;
   assign ev_data = w_pend_q ? w_data_q : WDATA;
   assign is_pass = eval & (ev_addr == TOHOST_ADDR) & (ev_data == DATA_W'(1));
   assign is_fail = eval & (ev_addr == TOHOST_ADDR) & ev_data[0] & (ev_data != DATA_W'(1));
   assign budget_exp = run & (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef SIM_CTRL_STALL_WDG_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (run) begin
         if (aw_hs | w_hs)
            stall_d = '0;
         else if (stall_q != '1)
            stall_d = stall_q + CNT_W'(1);
      end
   end

   assign stall_exp = run & ~(aw_hs | w_hs) & (stall_q == CNT_W'(STALL_CYCLES - 1));

   always_ff @(posedge ACLK) begin
      if (ARESET)
         stall_q <= '0;
      else
         stall_q <= stall_d;
   end
`else
   assign stall_exp = 1'b0;
`endif

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= RST_HOLD;
         hold_q    <= '0;
         cycle_q   <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         dut_rst_q <= 1'b1;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         tmo_q     <= 1'b0;
         exit_q    <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         cycle_q   <= cycle_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         aw_addr_q <= aw_addr_d;
         w_data_q  <= w_data_d;
         dut_rst_q <= dut_rst_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         tmo_q     <= tmo_d;
         exit_q    <= exit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RST_HOLD: if (hold_q == CNT_W'(RST_CYCLES - 1)) state_d = RUN;
         RUN: begin
            if (is_pass)
               state_d = PASS;
            else if (is_fail)
               state_d = FAIL;
            else if (stall_exp | budget_exp)
               state_d = TMO;
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      hold_d    = (state_q == RST_HOLD) ? hold_q + CNT_W'(1) : hold_q;
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
      aw_addr_d = aw_addr_q;
      w_data_d  = w_data_q;
      if (run && !eval) begin
         aw_pend_d = aw_pend_q | aw_take;
         w_pend_d  = w_pend_q | w_take;
         if (aw_take) aw_addr_d = AWADDR;
         if (w_take)  w_data_d  = WDATA;
      end
   end

   // Counter freezes on the edge that leaves RUN, so it reports the deciding cycle.
   always_comb begin
      dut_rst_d = (state_d == RST_HOLD);
      pass_d    = (state_d == PASS);
      fail_d    = (state_d == FAIL);
      tmo_d     = (state_d == TMO);
      done_d    = pass_d | fail_d | tmo_d;
      cycle_d   = cycle_q;
      exit_d    = exit_q;
      if (run && state_d == RUN && cycle_q != '1)
         cycle_d = cycle_q + CNT_W'(1);
      if (run && state_d == FAIL)
         exit_d = ev_data >> 1;
      else if (run && state_d == TMO && stall_exp)
         exit_d = '1;
   end

   assign dut_rst     = dut_rst_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = tmo_q;
   assign exit_code   = exit_q;
   assign cycle_count = cycle_q;

endmodule
